// File: rtl/screen_scheduler.sv
// Frame-synchronous COVER/PLAY/OVER screen sequencer that also generates the shared
// image-ROM address and latency-aligns every pixel source onto Din.
module screen_scheduler #(
    parameter int H_VIS       = 640,
    parameter int V_VIS       = 480,
    parameter int ROM_LAT     = 1,
    parameter int OVER_FRAMES = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        fin,
    input  logic [8:0]  row,
    input  logic [9:0]  col,
    input  logic        rdn,
    input  logic [11:0] snake_pixel,
    input  logic [11:0] cover_data,
    input  logic [11:0] over_data,
    output logic [18:0] rom_addr,
    output logic [11:0] Din,
    output logic [1:0]  mode,
    output logic        game_rst,
    output logic        game_en
);
    localparam int L = 1 + ROM_LAT;

    typedef enum logic [1:0] {
        S_COVER = 2'd0,
        S_PLAY  = 2'd1,
        S_OVER  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        pend_q, pend_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        game_rst_q, game_rst_d;
    logic [18:0] rom_addr_q, rom_addr_d;
    logic        req;
    logic        frame_end;

    // Pixel-aligned pipelines; index 0 is the newest pixel, L-1 drives Din.
    logic [L-1:0] rdn_q;
    state_e       sel_q [L];
    logic [11:0]  pix_q [L];

    assign frame_end = !rdn && (row == 9'(V_VIS - 1)) && (col == 10'(H_VIS - 1));

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        game_rst_d = 1'b0;
        req        = 1'b0;
        case (state_q)
            S_COVER: begin
                req    = pend_q | start;
                pend_d = req;
                if (frame_end && req) begin
                    state_d    = S_PLAY;
                    game_rst_d = 1'b1;
                end
            end
            S_PLAY: begin
                req    = pend_q | fin;
                pend_d = req;
                if (frame_end && req) state_d = S_OVER;
            end
            S_OVER: begin
                pend_d = 1'b0;
                if (frame_end) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == 8'(OVER_FRAMES)) state_d = S_COVER;
                end
            end
            default: state_d = S_COVER;
        endcase
        // Every screen change starts the new screen with no stale request or count.
        if (state_d != state_q) begin
            pend_d = 1'b0;
            cnt_d  = 8'd0;
        end
    end

    always_comb begin
        rom_addr_d = '0;
        if (row < 9'(V_VIS) && col < 10'(H_VIS))
            rom_addr_d = 19'(row) * 19'(H_VIS) + 19'(col);
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_COVER;
            pend_q     <= 1'b0;
            cnt_q      <= 8'd0;
            game_rst_q <= 1'b0;
            rom_addr_q <= '0;
            // NOTE: the short pixel pipeline is flushed on reset (unlike a RAM) so
            // Din is forced dark until fresh pixels have traversed it.
            rdn_q      <= '1;
            for (int i = 0; i < L; i++) begin
                sel_q[i] <= S_COVER;
                pix_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            game_rst_q <= game_rst_d;
            rom_addr_q <= rom_addr_d;
            rdn_q      <= {rdn_q[L-2:0], rdn};
            sel_q[0]   <= state_q;
            pix_q[0]   <= snake_pixel;
            for (int i = 1; i < L; i++) begin
                sel_q[i] <= sel_q[i-1];
                pix_q[i] <= pix_q[i-1];
            end
        end
    end

    always_comb begin
        Din = '0;
        if (!rdn_q[L-1]) begin
            case (sel_q[L-1])
                S_COVER: Din = cover_data;
                S_PLAY:  Din = pix_q[L-1];
                S_OVER:  Din = over_data;
                default: Din = '0;
            endcase
        end
    end

    assign rom_addr = rom_addr_q;
    assign mode     = state_q;
    assign game_rst = game_rst_q;
    assign game_en  = (state_q == S_PLAY);

endmodule
